// File: rtl/alsu_pipe.sv
// Two-stage handshaked ALSU: stage 1 captures operands on in_valid, stage 2 evaluates and
// commits out/err with a one-cycle out_valid pulse. A blink FSM drives the LED bank on errors.
module alsu_pipe #(
   parameter int    WIDTH          = 3,
   parameter string INPUT_PRIORITY = "A",
   parameter string FULL_ADDER     = "ON",
   parameter int    BLINK_CYCLES   = 100_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic [2:0]           opcode,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   input  logic                 direction,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic                 err,
   output logic [15:0]          leds,
   output logic                 dbg_blink_o
);

   localparam int OW      = 2 * WIDTH;
   localparam int CW      = $clog2(BLINK_CYCLES) + 1;
   localparam bit PRI_A   = (INPUT_PRIORITY == "A");
   localparam bit PRI_B   = (INPUT_PRIORITY == "B");
   localparam bit ADD_CIN = (FULL_ADDER == "ON");
   localparam logic [CW-1:0] TERM = CW'(BLINK_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, BLINK = 1'b1} state_t;

   // Stage-1 capture registers
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q, sin_q, red_a_q, red_b_q, byp_a_q, byp_b_q, dir_q, vld1_q;
   logic [2:0]       op_q;

   // Stage-2 result registers
   logic [OW-1:0]    out_q, out_d;
   logic             out_valid_q, err_q, err_d;

   // Blink FSM
   state_t           state_q, state_d;
   logic [15:0]      leds_q, leds_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] pri_op;
   logic             red_any;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         sin_q   <= 1'b0;
         red_a_q <= 1'b0;
         red_b_q <= 1'b0;
         byp_a_q <= 1'b0;
         byp_b_q <= 1'b0;
         dir_q   <= 1'b0;
         op_q    <= 3'b000;
         vld1_q  <= 1'b0;
      end else begin
         vld1_q <= in_valid;
         if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            cin_q   <= cin;
            sin_q   <= serial_in;
            red_a_q <= red_op_A;
            red_b_q <= red_op_B;
            byp_a_q <= bypass_A;
            byp_b_q <= bypass_B;
            dir_q   <= direction;
            op_q    <= opcode;
         end
      end
   end

   assign pri_op  = PRI_A ? a_q : (PRI_B ? b_q : '0);
   assign red_any = red_a_q | red_b_q;

   // Invalid ops leave out_d at out_q so the previous result is held
   always_comb begin
      out_d = out_q;
      err_d = 1'b0;
      if (byp_a_q && byp_b_q) begin
         out_d = OW'(pri_op);
      end else if (byp_a_q) begin
         out_d = OW'(a_q);
      end else if (byp_b_q) begin
         out_d = OW'(b_q);
      end else if (op_q[2:1] == 2'b11 || (red_any && op_q[2:1] != 2'b00)) begin
         err_d = 1'b1;
      end else begin
         case (op_q)
            3'b000: begin
               if (red_a_q && red_b_q) out_d = OW'(&pri_op);
               else if (red_a_q)       out_d = OW'(&a_q);
               else if (red_b_q)       out_d = OW'(&b_q);
               else                    out_d = OW'(a_q & b_q);
            end
            3'b001: begin
               if (red_a_q && red_b_q) out_d = OW'(^pri_op);
               else if (red_a_q)       out_d = OW'(^a_q);
               else if (red_b_q)       out_d = OW'(^b_q);
               else                    out_d = OW'(a_q ^ b_q);
            end
            3'b010: out_d = OW'(a_q) + OW'(b_q) + OW'(cin_q & ADD_CIN);
            3'b011: out_d = OW'(a_q) * OW'(b_q);
            3'b100: out_d = dir_q ? {out_q[OW-2:0], sin_q} : {sin_q, out_q[OW-1:1]};
            3'b101: out_d = dir_q ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
            default: out_d = out_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= vld1_q;
         err_q       <= vld1_q & err_d;
         if (vld1_q) out_q <= out_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         leds_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         leds_q  <= leds_d;
         cnt_q   <= cnt_d;
      end
   end

   // Errors while already blinking neither restart nor reset the period
   always_comb begin
      state_d = state_q;
      leds_d  = leds_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (out_valid_q && err_q) begin
               state_d = BLINK;
               leds_d  = 16'hFFFF;
               cnt_d   = '0;
            end
         end
         BLINK: begin
            if (out_valid_q && !err_q) begin
               state_d = IDLE;
               leds_d  = 16'h0000;
               cnt_d   = '0;
            end else if (cnt_q == TERM) begin
               leds_d = ~leds_q;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out         = out_q;
   assign out_valid   = out_valid_q;
   assign err         = err_q;
   assign leds        = leds_q;
   assign dbg_blink_o = (state_q == BLINK);

endmodule
